// File: rtl/lcd_rx_capture.sv
// Two-pixel-per-beat LCD frame capture with an AHB-Lite register slave.
// Counts pixels, lines and frames and keeps a 32-bit component checksum.
module lcd_rx_capture #(
    parameter int IMG_PIX_W = 8,
    parameter int W_SIZE    = 12,
    parameter int W_ADDR    = 32,
    parameter int W_DATA    = 32
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 in_valid,
    input  logic [IMG_PIX_W-1:0] in_r0,
    input  logic [IMG_PIX_W-1:0] in_g0,
    input  logic [IMG_PIX_W-1:0] in_b0,
    input  logic [IMG_PIX_W-1:0] in_r1,
    input  logic [IMG_PIX_W-1:0] in_g1,
    input  logic [IMG_PIX_W-1:0] in_b1,
    input  logic                 HSEL,
    input  logic [W_ADDR-1:0]    HADDR,
    input  logic [1:0]           HTRANS,
    input  logic                 HWRITE,
    input  logic [W_DATA-1:0]    HWDATA,
    input  logic                 HREADY,
    output logic [W_DATA-1:0]    HRDATA,
    output logic                 HREADYOUT,
    output logic [1:0]           HRESP,
    output logic                 frame_done
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t state_q, state_d;

    logic              dph_q, wr_q;
    logic [3:0]        addr_q;
    logic              ctrl_en;
    logic [W_SIZE-1:0] width_q, height_q, col_q;
    logic [31:0]       pix_q, line_q, chk_q, frm_q;
    logic              done_q, ovf_q, abort_q;

    logic              reg_wr, ctrl_wr, clr, en_eff, geom_ok;
    logic [W_SIZE:0]   col_nxt;
    logic [31:0]       line_nxt, rdata;
    logic              line_end, frame_end;
    logic [IMG_PIX_W+2:0] beat_sum;
    logic              arm, done_clr, take, ovf_set, abort_set;
    logic              unused_bits;

    assign unused_bits = ^{HADDR[W_ADDR-1:6], HADDR[1:0], HTRANS[0],
                           HWDATA[W_DATA-1:W_SIZE]};

    assign reg_wr  = dph_q & wr_q;
    assign ctrl_wr = reg_wr && addr_q == 4'd0;
    assign clr     = ctrl_wr & HWDATA[1];
    assign en_eff  = ctrl_wr ? HWDATA[0] : ctrl_en;
    assign geom_ok = (width_q != '0) && (height_q != '0);

    assign beat_sum = (IMG_PIX_W+3)'(in_r0) + (IMG_PIX_W+3)'(in_g0)
                    + (IMG_PIX_W+3)'(in_b0) + (IMG_PIX_W+3)'(in_r1)
                    + (IMG_PIX_W+3)'(in_g1) + (IMG_PIX_W+3)'(in_b1);

    // Odd widths round up: the compare is >= so the last beat overhangs.
    assign col_nxt   = {1'b0, col_q} + (W_SIZE+1)'(2);
    assign line_end  = col_nxt >= {1'b0, width_q};
    assign line_nxt  = line_q + 32'd1;
    assign frame_end = line_end && (line_nxt >= 32'(height_q));

    always_comb begin
        state_d   = state_q;
        arm       = 1'b0;
        done_clr  = 1'b0;
        take      = 1'b0;
        ovf_set   = 1'b0;
        abort_set = 1'b0;
        if (clr) begin
            state_d = en_eff ? ARMED : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ovf_set = in_valid;
                    if (en_eff) begin
                        state_d  = ARMED;
                        arm      = 1'b1;
                        done_clr = 1'b1;
                    end
                end
                ARMED: begin
                    if (!en_eff) begin
                        state_d   = IDLE;
                        abort_set = 1'b1;
                    end else if (in_valid && geom_ok) begin
                        take    = 1'b1;
                        state_d = frame_end ? DONE : CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (!en_eff) begin
                        state_d   = IDLE;
                        abort_set = 1'b1;
                    end else if (in_valid) begin
                        take    = 1'b1;
                        state_d = frame_end ? DONE : CAPTURE;
                    end
                end
                DONE: begin
                    ovf_set = in_valid;
                    state_d = en_eff ? ARMED : IDLE;
                    arm     = en_eff;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= IDLE;
            dph_q    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            ctrl_en  <= 1'b0;
            width_q  <= W_SIZE'(768);
            height_q <= W_SIZE'(512);
            col_q    <= '0;
            pix_q    <= '0;
            line_q   <= '0;
            chk_q    <= '0;
            frm_q    <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (HREADY) begin
                dph_q  <= HSEL & HTRANS[1];
                wr_q   <= HWRITE;
                addr_q <= HADDR[5:2];
            end
            if (ctrl_wr) ctrl_en <= HWDATA[0];
            if (reg_wr && addr_q == 4'd1) width_q  <= HWDATA[W_SIZE-1:0];
            if (reg_wr && addr_q == 4'd2) height_q <= HWDATA[W_SIZE-1:0];
            if (clr) begin
                col_q   <= '0;
                pix_q   <= '0;
                line_q  <= '0;
                chk_q   <= '0;
                frm_q   <= '0;
                done_q  <= 1'b0;
                ovf_q   <= 1'b0;
                abort_q <= 1'b0;
            end else begin
                if (arm) begin
                    col_q  <= '0;
                    pix_q  <= '0;
                    line_q <= '0;
                    chk_q  <= '0;
                end
                if (done_clr) done_q <= 1'b0;
                if (take) begin
                    pix_q <= pix_q + 32'd2;
                    chk_q <= chk_q + 32'(beat_sum);
                    col_q <= line_end ? '0 : col_nxt[W_SIZE-1:0];
                    if (line_end) line_q <= line_nxt;
                end
                if (take && frame_end) begin
                    done_q <= 1'b1;
                    frm_q  <= frm_q + 32'd1;
                end
                if (ovf_set) ovf_q <= 1'b1;
                if (abort_set) abort_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr_q)
            4'd0: rdata = {31'd0, ctrl_en};
            4'd1: rdata = 32'(width_q);
            4'd2: rdata = 32'(height_q);
            4'd3: rdata = {28'd0, abort_q, ovf_q, done_q,
                           (state_q == ARMED) || (state_q == CAPTURE)};
            4'd4: rdata = pix_q;
            4'd5: rdata = line_q;
            4'd6: rdata = chk_q;
            4'd7: rdata = frm_q;
            default: rdata = '0;
        endcase
    end

    assign HRDATA     = (dph_q && !wr_q) ? W_DATA'(rdata) : '0;
    assign HREADYOUT  = 1'b1;
    assign HRESP      = 2'b00;
    assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_lcd_rx_capture.sv
// Directed bench for lcd_rx_capture: frame table plus corner sequences.
module tb_lcd_rx_capture;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_r0 = '0, in_g0 = '0, in_b0 = '0;
    logic [7:0]  in_r1 = '0, in_g1 = '0, in_b1 = '0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic        HWRITE = 1'b0;
    logic [31:0] HWDATA = '0;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;
    int fd_count = 0;

    lcd_rx_capture dut (
        .HCLK(HCLK), .HRESET(HRESET), .in_valid(in_valid),
        .in_r0(in_r0), .in_g0(in_g0), .in_b0(in_b0),
        .in_r1(in_r1), .in_g1(in_g1), .in_b1(in_b1),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .frame_done(frame_done)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) if (frame_done) fd_count <= fd_count + 1;

    typedef struct {
        int          w, h, n;
        logic [7:0]  c;
        logic [31:0] pix, line, chk;
    } vec_t;

    vec_t tbl[5];

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_pix(logic [7:0] c);
        in_r0 = c; in_g0 = c; in_b0 = c;
        in_r1 = c; in_g1 = c; in_b1 = c;
    endtask

    task automatic ahb_write(logic [31:0] a, logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        step();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        step();
    endtask

    task automatic rd_chk(string name, logic [31:0] a, logic [31:0] exp);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        step();
        HSEL = 1'b0; HTRANS = 2'b00;
        check(name, HRDATA, exp);
        step();
    endtask

    task automatic beats(int n, logic [7:0] c);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            set_pix(c);
            step();
        end
        in_valid = 1'b0;
    endtask

    // Final beat overlaps the address phase of an EN=0 write so the
    // DONE cycle returns to IDLE and the counters stay readable.
    task automatic frame_stop(int n, logic [7:0] c);
        int fd0;
        logic early;
        fd0 = fd_count;
        early = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            set_pix(c);
            if (i == n - 1) begin
                HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
            end
            if (frame_done) early = 1'b1;
            step();
        end
        in_valid = 1'b0;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h0;
        check("frame_done_pulse", {31'd0, frame_done}, 32'd1);
        step();
        check("frame_done_end", {31'd0, frame_done}, 32'd0);
        check("frame_done_early", {31'd0, early}, 32'd0);
        check("frame_done_count", 32'(fd_count - fd0), 32'd1);
    endtask

    task automatic setup(int w, int h);
        ahb_write(32'h04, 32'(w));
        ahb_write(32'h08, 32'(h));
        ahb_write(32'h00, 32'h3);
    endtask

    initial begin
        int fd0;
        logic [31:0] exp_chk;

        tbl[0] = '{w: 4, h: 2, n: 4, c: 8'h01, pix: 8,  line: 2, chk: 24};
        tbl[1] = '{w: 5, h: 2, n: 6, c: 8'h02, pix: 12, line: 2, chk: 72};
        tbl[2] = '{w: 2, h: 3, n: 3, c: 8'h10, pix: 6,  line: 3, chk: 288};
        tbl[3] = '{w: 6, h: 1, n: 3, c: 8'hFF, pix: 6,  line: 1, chk: 4590};
        tbl[4] = '{w: 1, h: 1, n: 1, c: 8'h07, pix: 2,  line: 1, chk: 42};

        repeat (2) step();
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_hrdata", HRDATA, 32'd0);
        check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("rst_hresp", {30'd0, HRESP}, 32'd0);
        HRESET = 1'b0;
        step();
        rd_chk("rst_ctrl", 32'h00, 32'd0);
        rd_chk("rst_width", 32'h04, 32'd768);
        rd_chk("rst_height", 32'h08, 32'd512);
        rd_chk("rst_status", 32'h0C, 32'd0);
        rd_chk("rst_pix", 32'h10, 32'd0);
        rd_chk("rst_frames", 32'h1C, 32'd0);

        for (int i = 0; i < 5; i++) begin
            setup(tbl[i].w, tbl[i].h);
            frame_stop(tbl[i].n, tbl[i].c);
            rd_chk("tbl_pix", 32'h10, tbl[i].pix);
            rd_chk("tbl_line", 32'h14, tbl[i].line);
            rd_chk("tbl_chk", 32'h18, tbl[i].chk);
            rd_chk("tbl_frames", 32'h1C, 32'd1);
            rd_chk("tbl_status", 32'h0C, 32'h2);
        end

        // extra beat after the frame with EN low
        setup(4, 2);
        frame_stop(4, 8'h01);
        beats(1, 8'h01);
        rd_chk("ovf_status", 32'h0C, 32'h6);
        rd_chk("ovf_pix", 32'h10, 32'd8);

        // EN held high through frame end: re-arm, DONE retained
        setup(4, 1);
        beats(2, 8'h01);
        check("rearm_pulse", {31'd0, frame_done}, 32'd1);
        step();
        check("rearm_pulse_end", {31'd0, frame_done}, 32'd0);
        rd_chk("rearm_status", 32'h0C, 32'h3);
        rd_chk("rearm_pix", 32'h10, 32'd0);
        rd_chk("rearm_frames", 32'h1C, 32'd1);
        ahb_write(32'h00, 32'h0);

        // abort after 3 of 4 beats
        setup(4, 2);
        fd0 = fd_count;
        beats(3, 8'h01);
        ahb_write(32'h00, 32'h0);
        rd_chk("abort_status", 32'h0C, 32'h8);
        rd_chk("abort_pix", 32'h10, 32'd6);
        check("abort_no_pulse", 32'(fd_count - fd0), 32'd0);

        // CLR coincident with a beat
        setup(4, 2);
        beats(2, 8'h01);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
        step();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h2;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rd_chk("clr_pix", 32'h10, 32'd0);
        rd_chk("clr_line", 32'h14, 32'd0);
        rd_chk("clr_chk", 32'h18, 32'd0);
        rd_chk("clr_status", 32'h0C, 32'd0);

        // zero width holds ARMED, nothing counted, no OVF
        setup(0, 2);
        beats(2, 8'h01);
        rd_chk("w0_status", 32'h0C, 32'h1);
        rd_chk("w0_pix", 32'h10, 32'd0);
        ahb_write(32'h00, 32'h2);

        // width shrunk mid-line
        setup(8, 2);
        beats(1, 8'h01);
        ahb_write(32'h04, 32'd4);
        beats(1, 8'h01);
        rd_chk("wchg_line", 32'h14, 32'd1);
        rd_chk("wchg_pix", 32'h10, 32'd4);
        ahb_write(32'h00, 32'h2);

        // back-to-back write then read, unmapped read
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h04;
        step();
        HWRITE = 1'b0; HWDATA = 32'h123;
        step();
        HSEL = 1'b0; HTRANS = 2'b00;
        check("b2b_rdata", HRDATA, 32'h123);
        check("b2b_ready", {31'd0, HREADYOUT}, 32'd1);
        check("b2b_resp", {30'd0, HRESP}, 32'd0);
        step();
        rd_chk("unmapped_20", 32'h20, 32'd0);
        ahb_write(32'h0C, 32'hF);
        rd_chk("status_ro", 32'h0C, 32'd0);

        // wide frame, saturated components
        setup(768, 16);
        frame_stop(6144, 8'hFF);
        exp_chk = 32'd6144 * 32'd1530;
        rd_chk("big_pix", 32'h10, 32'd12288);
        rd_chk("big_line", 32'h14, 32'd16);
        rd_chk("big_chk", 32'h18, exp_chk);
        rd_chk("big_frames", 32'h1C, 32'd1);

        // reset in the middle of a frame
        setup(4, 2);
        fd0 = fd_count;
        beats(3, 8'h01);
        in_valid = 1'b1;
        HRESET = 1'b1;
        #1;
        check("midrst_frame_done", {31'd0, frame_done}, 32'd0);
        check("midrst_hrdata", HRDATA, 32'd0);
        step();
        step();
        HRESET = 1'b0;
        in_valid = 1'b0;
        step();
        check("midrst_no_pulse", 32'(fd_count - fd0), 32'd0);
        rd_chk("midrst_status", 32'h0C, 32'd0);
        rd_chk("midrst_pix", 32'h10, 32'd0);
        rd_chk("midrst_width", 32'h04, 32'd768);
        rd_chk("midrst_ctrl", 32'h00, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
